// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code values, FSM states and
// small op-class helpers, also used by the control unit.
package alu_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_ADDU  = 5'd10;
  localparam logic [4:0] OP_SUBU  = 5'd11;
  localparam logic [4:0] OP_SLTU  = 5'd12;
  localparam logic [4:0] OP_XOR   = 5'd13;
  localparam logic [4:0] OP_MULT  = 5'd14;
  localparam logic [4:0] OP_MULTU = 5'd15;
  localparam logic [4:0] OP_DIV   = 5'd16;
  localparam logic [4:0] OP_DIVU  = 5'd17;
  localparam logic [4:0] OP_MFHI  = 5'd18;
  localparam logic [4:0] OP_MFLO  = 5'd19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ONE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_e;

  function automatic logic op_is_muldiv(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed_md(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);

  logic             start;
  logic [4:0]       ALUOp;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, ALUOp, rs, rt, shamt,
    input  result, zero, overflow, div_by_zero, busy, done, hi, lo
  );

  modport slave (
    input  start, ALUOp, rs, rt, shamt,
    output result, zero, overflow, div_by_zero, busy, done, hi, lo
  );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide engine: captures operand magnitudes, runs WIDTH
// shift-add or restoring-divide steps, then presents sign-corrected hi/lo.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  logic             running_q, running_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic             div_q, div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  // acc holds the product high half / partial remainder; mq holds the
  // multiplier being consumed or the dividend being replaced by quotient bits.
  always_comb begin
    running_d = running_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mb_d      = mb_q;
    div_d     = div_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    dbz_d     = dbz_q;

    mul_sum = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mb_q : '0)};
    shifted = {acc_q, mq_q[WIDTH-1]};
    diff    = shifted - {1'b0, mb_q};

    if (start) begin
      neg_a_d   = is_signed & a[WIDTH-1];
      neg_b_d   = is_signed & b[WIDTH-1];
      acc_d     = '0;
      mq_d      = neg_a_d ? -a : a;
      mb_d      = neg_b_d ? -b : b;
      div_d     = is_div;
      dbz_d     = is_div && (b == '0);
      count_d   = '0;
      running_d = 1'b1;
    end else if (running_q) begin
      if (div_q) begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
      end
      count_d = count_q + CW'(1);
      if (count_q == CW'(WIDTH - 1)) begin
        running_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      running_q <= 1'b0;
      count_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      mb_q      <= '0;
      div_q     <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      running_q <= running_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mb_q      <= mb_d;
      div_q     <= div_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      dbz_q     <= dbz_d;
    end
  end

  assign done = running_q && (count_q == CW'(WIDTH - 1));

  // Sign fix-up; the remainder follows the dividend so division truncates toward zero.
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -{acc_q, mq_q} : {acc_q, mq_q};
    hi   = prod[2*WIDTH-1:WIDTH];
    lo   = prod[WIDTH-1:0];
    if (div_q) begin
      if (dbz_q) begin
        hi = a;
        lo = '1;
      end else begin
        lo = (neg_a_q ^ neg_b_q) ? -mq_q : mq_q;
        hi = neg_a_q ? -acc_q : acc_q;
      end
    end
  end

  assign div_by_zero = dbz_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential MIPS ALU: single-cycle ops computed here, MUL/DIV delegated to
// alu_muldiv, all results and flags registered behind a start/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clock,
  input  logic     reset,
  alu_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             go_q, go_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             accept;
  logic             md_done;
  logic             md_dbz;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock       (clock),
    .reset       (reset),
    .start       (go_q),
    .is_div      (op_is_div(op_q)),
    .is_signed   (op_is_signed_md(op_q)),
    .a           (rs_q),
    .b           (rt_q),
    .done        (md_done),
    .hi          (md_hi),
    .lo          (md_lo),
    .div_by_zero (md_dbz)
  );

  // Single-cycle datapath, evaluated on the operands captured at acceptance.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = rs_q + rt_q;
    diff    = rs_q - rt_q;
    case (op_q)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (rs_q[WIDTH-1] == rt_q[WIDTH-1]) && (sum[WIDTH-1] != rs_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (rs_q[WIDTH-1] != rt_q[WIDTH-1]) && (diff[WIDTH-1] != rs_q[WIDTH-1]);
      end
      OP_AND:  alu_res = rs_q & rt_q;
      OP_OR:   alu_res = rs_q | rt_q;
      OP_NOR:  alu_res = ~(rs_q | rt_q);
      OP_XOR:  alu_res = rs_q ^ rt_q;
      OP_SLT:  alu_res = WIDTH'($signed(rs_q) < $signed(rt_q));
      OP_SLTU: alu_res = WIDTH'(rs_q < rt_q);
      OP_SLL:  alu_res = rt_q << shamt_q;
      OP_SRL:  alu_res = rt_q >> shamt_q;
      OP_SRA:  alu_res = $signed(rt_q) >>> shamt_q;
      OP_ADDU: alu_res = sum;
      OP_SUBU: alu_res = diff;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Requests are only taken in IDLE or ONE, so back-to-back single-cycle ops
  // stream every cycle while MUL/DIV/FIX ignore start without queueing.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    shamt_d    = shamt_q;
    result_d   = result_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    go_d       = 1'b0;
    accept     = bus.start && ((state_q == ST_IDLE) || (state_q == ST_ONE));

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_ONE: begin
        state_d    = ST_IDLE;
        result_d   = alu_res;
        zero_d     = (alu_res == '0);
        overflow_d = alu_ovf;
        dbz_d      = 1'b0;
        done_d     = 1'b1;
      end
      ST_MUL, ST_DIV: begin
        if (md_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d    = ST_IDLE;
        hi_d       = md_hi;
        lo_d       = md_lo;
        result_d   = md_lo;
        zero_d     = (md_lo == '0);
        overflow_d = 1'b0;
        dbz_d      = md_dbz;
        done_d     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      op_d    = bus.ALUOp;
      rs_d    = bus.rs;
      rt_d    = bus.rt;
      shamt_d = bus.shamt;
      if (op_is_muldiv(bus.ALUOp)) begin
        state_d = op_is_div(bus.ALUOp) ? ST_DIV : ST_MUL;
        go_d    = 1'b1;
      end else begin
        state_d = ST_ONE;
      end
    end

    busy_d = ((state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX)) &&
             ((state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      rs_q       <= '0;
      rt_q       <= '0;
      shamt_q    <= '0;
      result_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      shamt_q    <= shamt_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      dbz_q      <= dbz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      go_q       <= go_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH 32 and 16: directed plan cases plus random ops,
// checked against a 64-bit arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] hi_model [2];
  logic [63:0] lo_model [2];
  logic [63:0] o_result, o_hi, o_lo;
  logic        o_zero, o_overflow, o_dbz, o_busy, o_done;

  always #5 clock = ~clock;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  alu_seq #(.WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16));

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int width_of(input int sel);
    return (sel == 0) ? 32 : 16;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(input logic [63:0] v, input int w);
    logic [63:0] t;
    t = v << (64 - w);
    return $signed(t) >>> (64 - w);
  endfunction

  // Reference behaviour from the arithmetic definitions of each op.
  function automatic void ref_model(input int w, input logic [4:0] op,
                                    input logic [63:0] a, input logic [63:0] b,
                                    input logic [63:0] sh, input logic [63:0] hi_in,
                                    input logic [63:0] lo_in, output logic [63:0] res,
                                    output logic [63:0] hi_o, output logic [63:0] lo_o,
                                    output logic ovf, output logic dbz, output int lat);
    logic [63:0] m;
    longint      sa, sb, s, q, r;
    logic [63:0] pu;
    m = mask_of(w);
    sa = sext(a, w);
    sb = sext(b, w);
    hi_o = hi_in;
    lo_o = lo_in;
    res = '0;
    ovf = 1'b0;
    dbz = 1'b0;
    lat = 1;
    case (op)
      OP_ADD:  begin s = sa + sb; res = s & m; ovf = (s != sext(res, w)); end
      OP_SUB:  begin s = sa - sb; res = s & m; ovf = (s != sext(res, w)); end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b) & m;
      OP_XOR:  res = a ^ b;
      OP_SLT:  res = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLTU: res = (a < b) ? 64'd1 : 64'd0;
      OP_SLL:  res = (b << sh) & m;
      OP_SRL:  res = b >> sh;
      OP_SRA:  res = (sb >>> sh) & m;
      OP_ADDU: res = (a + b) & m;
      OP_SUBU: res = (a - b) & m;
      OP_MULT, OP_MULTU: begin
        pu = (op == OP_MULT) ? 64'(sa * sb) : a * b;
        hi_o = (pu >> w) & m;
        lo_o = pu & m;
        res = lo_o;
        lat = w + 2;
      end
      OP_DIV, OP_DIVU: begin
        lat = w + 2;
        if (b == 64'd0) begin
          hi_o = a;
          lo_o = m;
          dbz = 1'b1;
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          lo_o = q & m;
          hi_o = r & m;
        end else begin
          lo_o = a / b;
          hi_o = a % b;
        end
        res = lo_o;
      end
      OP_MFHI: res = hi_in;
      OP_MFLO: res = lo_in;
      default: res = '0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sample_outputs(input int sel);
    if (sel == 0) begin
      o_result = 64'(bus32.result); o_hi = 64'(bus32.hi); o_lo = 64'(bus32.lo);
      o_zero = bus32.zero; o_overflow = bus32.overflow; o_dbz = bus32.div_by_zero;
      o_busy = bus32.busy; o_done = bus32.done;
    end else begin
      o_result = 64'(bus16.result); o_hi = 64'(bus16.hi); o_lo = 64'(bus16.lo);
      o_zero = bus16.zero; o_overflow = bus16.overflow; o_dbz = bus16.div_by_zero;
      o_busy = bus16.busy; o_done = bus16.done;
    end
  endtask

  task automatic drive_bus(input int sel, input logic st, input logic [4:0] op,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] sh);
    if (sel == 0) begin
      bus32.start = st; bus32.ALUOp = op; bus32.rs = a[31:0]; bus32.rt = b[31:0];
      bus32.shamt = sh[4:0];
    end else begin
      bus16.start = st; bus16.ALUOp = op; bus16.rs = a[15:0]; bus16.rt = b[15:0];
      bus16.shamt = sh[3:0];
    end
  endtask

  // One full transaction; operands are scrambled after acceptance and an
  // optional ADD request is raised mid-operation to show it is ignored.
  task automatic applyStimulus(input int sel, input string tag, input logic [4:0] op,
                               input logic [63:0] a_in, input logic [63:0] b_in,
                               input logic [63:0] sh_in, input bit intrude);
    int          w, lat, exp_lat, busy_cycles;
    logic [63:0] m, a, b, sh, exp_res, exp_hi, exp_lo;
    logic        exp_ovf, exp_dbz, got;
    w = width_of(sel);
    m = mask_of(w);
    a = a_in & m;
    b = b_in & m;
    sh = sh_in & 64'(w - 1);
    ref_model(w, op, a, b, sh, hi_model[sel], lo_model[sel], exp_res, exp_hi, exp_lo,
              exp_ovf, exp_dbz, exp_lat);
    @(negedge clock);
    drive_bus(sel, 1'b1, op, a, b, sh);
    @(posedge clock);
    #1;
    drive_bus(sel, 1'b0, op, {$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom));
    lat = 0;
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clock);
      #1;
      sample_outputs(sel);
      lat++;
      if (o_busy) busy_cycles++;
      if (o_done) got = 1'b1;
      if (intrude && i == 4) drive_bus(sel, 1'b1, OP_ADD, 64'h55, 64'h1, 64'd0);
      if (intrude && i == 5) drive_bus(sel, 1'b0, OP_ADD, 64'h55, 64'h1, 64'd0);
    end
    checkOutput({tag, " done_seen"}, 64'(got), 64'd1);
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, " busy_cycles"}, 64'(busy_cycles), (exp_lat > 1) ? 64'(w + 1) : 64'd0);
    checkOutput({tag, " result"}, o_result, exp_res);
    checkOutput({tag, " zero"}, 64'(o_zero), 64'(exp_res == 64'd0));
    checkOutput({tag, " overflow"}, 64'(o_overflow), 64'(exp_ovf));
    checkOutput({tag, " div_by_zero"}, 64'(o_dbz), 64'(exp_dbz));
    checkOutput({tag, " hi"}, o_hi, exp_hi);
    checkOutput({tag, " lo"}, o_lo, exp_lo);
    hi_model[sel] = exp_hi;
    lo_model[sel] = exp_lo;
  endtask

  task automatic idle_check(input int sel, input int n, input string tag);
    int extra;
    extra = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      sample_outputs(sel);
      if (o_done) extra++;
    end
    checkOutput(tag, 64'(extra), 64'd0);
  endtask

  function automatic logic [63:0] pick_operand(input int w);
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return mask_of(w);
      3: return 64'd1 << (w - 1);
      default: return {$urandom, $urandom} & mask_of(w);
    endcase
  endfunction

  initial begin
    hi_model[0] = '0; lo_model[0] = '0;
    hi_model[1] = '0; lo_model[1] = '0;
    drive_bus(0, 1'b0, OP_NOP, 64'd0, 64'd0, 64'd0);
    drive_bus(1, 1'b0, OP_NOP, 64'd0, 64'd0, 64'd0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample_outputs(s);
      checkOutput("reset result", o_result, 64'd0);
      checkOutput("reset zero", 64'(o_zero), 64'd1);
      checkOutput("reset flags", {o_overflow, o_dbz, o_busy, o_done}, 64'd0);
      checkOutput("reset hi_lo", o_hi | o_lo, 64'd0);
    end
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(0, "add_ovf", OP_ADD, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0);
    checkOutput("add_ovf const", {o_result[31:0], 31'd0, o_overflow}, {32'h8000_0000, 32'd1});
    applyStimulus(0, "addu_no_ovf", OP_ADDU, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0);
    applyStimulus(0, "slt", OP_SLT, 64'hFFFF_FFFF, 64'd1, 64'd0, 1'b0);
    applyStimulus(0, "sltu", OP_SLTU, 64'hFFFF_FFFF, 64'd1, 64'd0, 1'b0);
    applyStimulus(0, "sra", OP_SRA, 64'd0, 64'h8000_0000, 64'd4, 1'b0);
    checkOutput("sra const", o_result, 64'hF800_0000);
    applyStimulus(0, "sub_zero", OP_SUB, 64'd5, 64'd5, 64'd0, 1'b0);
    applyStimulus(0, "mult", OP_MULT, 64'hFFFF_FFFD, 64'd7, 64'd0, 1'b0);
    checkOutput("mult const", {o_hi[31:0], o_lo[31:0]}, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus(0, "multu", OP_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 1'b0);
    applyStimulus(0, "div", OP_DIV, 64'hFFFF_FFF9, 64'd2, 64'd0, 1'b0);
    checkOutput("div const", {o_hi[31:0], o_lo[31:0]}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(0, "divu_by_zero", OP_DIVU, 64'd7, 64'd0, 64'd0, 1'b0);
    applyStimulus(0, "mfhi", OP_MFHI, 64'd0, 64'd0, 64'd0, 1'b0);
    checkOutput("mfhi const", o_result, 64'd7);
    applyStimulus(0, "div_min_by_m1", OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b0);
    applyStimulus(0, "mult_intruded", OP_MULT, 64'd12345, 64'hFFFF_E57B, 64'd0, 1'b1);
    idle_check(0, 5, "no_extra_done");

    // Two single-cycle ops on consecutive edges, then nothing.
    @(negedge clock);
    drive_bus(0, 1'b1, OP_ADD, 64'd3, 64'd4, 64'd0);
    @(posedge clock);
    #1;
    drive_bus(0, 1'b1, OP_XOR, 64'hF0, 64'hFF, 64'd0);
    @(posedge clock);
    #1;
    sample_outputs(0);
    checkOutput("b2b first", {o_result, 63'd0, o_done}, {64'd7, 64'd1});
    drive_bus(0, 1'b0, OP_NOP, 64'd0, 64'd0, 64'd0);
    @(posedge clock);
    #1;
    sample_outputs(0);
    checkOutput("b2b second", {o_result, 63'd0, o_done}, {64'h0F, 64'd1});

    // Reset in the middle of a division.
    @(negedge clock);
    drive_bus(0, 1'b1, OP_DIV, 64'd100, 64'd7, 64'd0);
    @(posedge clock);
    #1;
    drive_bus(0, 1'b0, OP_NOP, 64'd0, 64'd0, 64'd0);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    sample_outputs(0);
    checkOutput("rst_mid busy", 64'(o_busy), 64'd0);
    checkOutput("rst_mid done", 64'(o_done), 64'd0);
    checkOutput("rst_mid hi", o_hi, 64'd0);
    checkOutput("rst_mid lo", o_lo, 64'd0);
    checkOutput("rst_mid zero", 64'(o_zero), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    hi_model[0] = '0;
    lo_model[0] = '0;
    idle_check(0, 40, "rst_mid no_done");

    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, $sformatf("rand32_%0d", i), 5'($urandom_range(0, 23)),
                    pick_operand(32), pick_operand(32), 64'($urandom), 1'b0);
    end

    applyStimulus(1, "mult16", OP_MULT, 64'hFFFD, 64'd7, 64'd0, 1'b0);
    checkOutput("mult16 const", {o_hi[15:0], o_lo[15:0]}, 64'hFFFF_FFEB);
    applyStimulus(1, "sra16", OP_SRA, 64'd0, 64'h8000, 64'd4, 1'b0);
    checkOutput("sra16 const", o_result, 64'hF800);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, $sformatf("rand16_%0d", i), 5'($urandom_range(0, 23)),
                    pick_operand(16), pick_operand(16), 64'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
